// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the ram_arbiter slice.
//   - RAM read codes (load width / sign handling) and write codes (store width)
//   - arbiter FSM state encoding
//   - requester port identifiers
// No ports; imported by ram_arbiter, arb_grant and the testbench.
package mem_pkg;

    localparam logic [2:0] MEM_READ_NONE = 3'd0;
    localparam logic [2:0] MEM_READ_LB   = 3'd1;
    localparam logic [2:0] MEM_READ_LH   = 3'd2;
    localparam logic [2:0] MEM_READ_LW   = 3'd3;
    localparam logic [2:0] MEM_READ_LBU  = 3'd4;
    localparam logic [2:0] MEM_READ_LHU  = 3'd5;

    localparam logic [1:0] MEM_WRITE_NONE = 2'd0;
    localparam logic [1:0] MEM_WRITE_B    = 2'd1;
    localparam logic [1:0] MEM_WRITE_H    = 2'd2;
    localparam logic [1:0] MEM_WRITE_W    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the fetch port, the data port and the RAM port of
// ram_arbiter.
//   slave  modport : the arbiter's view (requests in, responses and RAM command out)
//   master modport : the requesters' + RAM's view (the opposite directions)
//
// Handshake: a request transfers on a cycle where *_req_valid && *_req_ready.
// The requester holds valid and payload stable until that cycle; ready may
// depend combinationally on valid. Responses (*_rsp_valid) are single-cycle
// pulses with no backpressure.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rsp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [2:0]            d_read;
    logic [1:0]            d_write;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rsp_data;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [2:0]            ram_mem_read;
    logic [1:0]            ram_mem_write;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_addr, d_wdata, d_read, d_write,
        input  ram_data_out,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output ram_address, ram_data_in, ram_mem_read, ram_mem_write
    );

    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_addr, d_wdata, d_read, d_write,
        output ram_data_out,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  ram_address, ram_data_in, ram_mem_read, ram_mem_write
    );

endinterface

// File: rtl/arb_grant.sv
// arb_grant: combinational grant pick between the fetch and data requesters.
//   i_if_valid, i_d_valid : request valids
//   i_last_port           : last granted port (only with ARB_ROUND_ROBIN_EN)
//   o_gnt_valid           : some port is requesting
//   o_gnt_port            : PORT_IF or PORT_D
// Macro ARB_ROUND_ROBIN_EN: ties alternate against the last grant;
// otherwise data always wins a tie.
module arb_grant
    import mem_pkg::*;
(
    input  logic i_if_valid,
    input  logic i_d_valid,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_port,
`endif
    output logic o_gnt_valid,
    output logic o_gnt_port
);

    always_comb begin
        o_gnt_valid = i_if_valid | i_d_valid;
        o_gnt_port  = i_d_valid ? PORT_D : PORT_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_if_valid && i_d_valid) begin
            o_gnt_port = (i_last_port == PORT_D) ? PORT_IF : PORT_D;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serializes instruction fetches and load/store requests onto
// the single shared RAM port, holds each command for RAM_LATENCY cycles and
// returns the result to the requester that issued it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_arbiter_if.slave (fetch port, data port, RAM port)
//   o_state  : current FSM state, for debug/observation
// Macro ARB_ROUND_ROBIN_EN: alternating tie priority via a last-grant pointer;
// without it data has fixed priority over fetch.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
)(
    input  logic                clk,
    input  logic                rst,
    ram_arbiter_if.slave        bus,
    output arb_state_t          o_state
);

    localparam logic [2:0] LAT = 3'(RAM_LATENCY);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_owner;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_read;
    logic [1:0]            r_write;
    logic [DATA_WIDTH-1:0] r_if_rsp_data;
    logic [DATA_WIDTH-1:0] r_d_rsp_data;

    logic w_gnt_valid;
    logic w_gnt_port;
    logic w_fire;
    logic w_last_cycle;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_port;

    arb_grant u_grant (
        .i_if_valid  (bus.if_req_valid),
        .i_d_valid   (bus.d_req_valid),
        .i_last_port (r_last_port),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_port  (w_gnt_port)
    );

    // Reset to fetch so that data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_port <= PORT_IF;
        end else if (w_fire) begin
            r_last_port <= w_gnt_port;
        end
    end
`else
    arb_grant u_grant (
        .i_if_valid  (bus.if_req_valid),
        .i_d_valid   (bus.d_req_valid),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_port  (w_gnt_port)
    );
`endif

    // Ready is gated by rst so nothing appears accepted while in reset.
    assign w_fire       = (r_state == ST_IDLE) && w_gnt_valid && !rst;
    assign w_last_cycle = (r_state == ST_ACCESS) && (r_cnt == 3'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_fire) w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_last_cycle) w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Command, counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner       <= PORT_IF;
            r_cnt         <= 3'd0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_read        <= MEM_READ_NONE;
            r_write       <= MEM_WRITE_NONE;
            r_if_rsp_data <= '0;
            r_d_rsp_data  <= '0;
        end else begin
            if (w_fire) begin
                r_owner <= w_gnt_port;
                r_cnt   <= LAT;
                if (w_gnt_port == PORT_IF) begin
                    r_addr  <= bus.if_addr;
                    r_read  <= MEM_READ_LW;
                    r_write <= MEM_WRITE_NONE;
                end else begin
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                    r_write <= bus.d_write;
                    // A combined load/store performs only the store.
                    r_read  <= (bus.d_write != MEM_WRITE_NONE) ? MEM_READ_NONE : bus.d_read;
                end
            end
            if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_last_cycle) begin
                if (r_owner == PORT_IF) begin
                    r_if_rsp_data <= bus.ram_data_out;
                end else begin
                    // Stores and no-ops report 0 rather than whatever the RAM drives.
                    r_d_rsp_data <= (r_read == MEM_READ_NONE) ? '0 : bus.ram_data_out;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        bus.if_req_ready  = w_fire && (w_gnt_port == PORT_IF);
        bus.d_req_ready   = w_fire && (w_gnt_port == PORT_D);
        bus.if_rsp_valid  = (r_state == ST_RESP) && (r_owner == PORT_IF);
        bus.d_rsp_valid   = (r_state == ST_RESP) && (r_owner == PORT_D);
        bus.if_rsp_data   = r_if_rsp_data;
        bus.d_rsp_data    = r_d_rsp_data;
        bus.ram_address   = r_addr;
        bus.ram_data_in   = r_wdata;
        bus.ram_mem_read  = (r_state == ST_ACCESS) ? r_read : MEM_READ_NONE;
        // The counter still equals LAT only in the first ACCESS cycle: one write per store.
        bus.ram_mem_write = ((r_state == ST_ACCESS) && (r_cnt == LAT)) ? r_write : MEM_WRITE_NONE;
        o_state           = r_state;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with
// RAM_LATENCY=1 and a small byte-addressed RAM model (combinational read,
// write on the clock edge) attached to the RAM port.
module tb_ram_arbiter;
    import mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    arb_state_t state;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (state)
    );

    // ---------------- RAM model ----------------
    logic [7:0]    mem [0:255];
    logic [DW-1:0] ram_rd;
    logic [7:0]    ra;

    always_comb begin
        ra     = bus.ram_address[7:0];
        ram_rd = '0;
        case (bus.ram_mem_read)
            MEM_READ_LB:  ram_rd = {{24{mem[ra][7]}}, mem[ra]};
            MEM_READ_LH:  ram_rd = {{16{mem[8'(ra + 8'd1)][7]}}, mem[8'(ra + 8'd1)], mem[ra]};
            MEM_READ_LW:  ram_rd = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};
            MEM_READ_LBU: ram_rd = {24'd0, mem[ra]};
            MEM_READ_LHU: ram_rd = {16'd0, mem[8'(ra + 8'd1)], mem[ra]};
            default:      ram_rd = '0;
        endcase
    end
    assign bus.ram_data_out = ram_rd;

    always @(posedge clk) begin
        case (bus.ram_mem_write)
            MEM_WRITE_B: mem[ra] <= bus.ram_data_in[7:0];
            MEM_WRITE_H: begin
                mem[ra]              <= bus.ram_data_in[7:0];
                mem[8'(ra + 8'd1)]   <= bus.ram_data_in[15:8];
            end
            MEM_WRITE_W: begin
                mem[ra]              <= bus.ram_data_in[7:0];
                mem[8'(ra + 8'd1)]   <= bus.ram_data_in[15:8];
                mem[8'(ra + 8'd2)]   <= bus.ram_data_in[23:16];
                mem[8'(ra + 8'd3)]   <= bus.ram_data_in[31:24];
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard / checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int d_rsp_cnt = 0;

    always @(negedge clk) begin
        if (bus.d_rsp_valid) d_rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_d_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.d_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(ok), 32'd1);
    endtask

    // One data transaction, checked cycle by cycle: fire, ACCESS, RESP, idle.
    task automatic d_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] rd, input logic [1:0] wr,
                         input logic [2:0] exp_rd, input logic [1:0] exp_wr,
                         input logic [31:0] exp_rsp);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = addr;
        bus.d_wdata     = wdata;
        bus.d_read      = rd;
        bus.d_write     = wr;
        wait_d_ready(tag);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_acc_state"}, 32'(state), 32'(ST_ACCESS));
        check({tag, "_acc_rd"}, 32'(bus.ram_mem_read), 32'(exp_rd));
        check({tag, "_acc_wr"}, 32'(bus.ram_mem_write), 32'(exp_wr));
        check({tag, "_acc_addr"}, bus.ram_address, addr);
        if (wr != MEM_WRITE_NONE) check({tag, "_acc_wdata"}, bus.ram_data_in, wdata);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(bus.d_rsp_valid), 32'd1);
        check({tag, "_rsp_data"}, bus.d_rsp_data, exp_rsp);
        check({tag, "_rsp_wr"}, 32'(bus.ram_mem_write), 32'd0);
        check({tag, "_rsp_rd"}, 32'(bus.ram_mem_read), 32'd0);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(bus.d_rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] exp_g [4];
    logic [1:0] who;
    int         snap;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[20] = 8'd7;

        bus.if_req_valid = 1'b0;
        bus.if_addr      = '0;
        bus.d_req_valid  = 1'b0;
        bus.d_addr       = '0;
        bus.d_wdata      = '0;
        bus.d_read       = '0;
        bus.d_write      = '0;

`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'd1; exp_g[1] = 2'd0; exp_g[2] = 2'd1; exp_g[3] = 2'd0;
`else
        exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1; exp_g[3] = 2'd1;
`endif

        // Reset state, including requests presented while in reset.
        repeat (3) @(posedge clk);
        #1;
        bus.if_req_valid = 1'b1;
        bus.d_req_valid  = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
        check("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
        check("rst_if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
        check("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
        check("rst_mem_read", 32'(bus.ram_mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.ram_mem_write), 32'd0);
        check("rst_address", bus.ram_address, 32'd0);
        check("rst_data_in", bus.ram_data_in, 32'd0);
        check("rst_if_rsp_data", bus.if_rsp_data, 32'd0);
        check("rst_d_rsp_data", bus.d_rsp_data, 32'd0);
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        rst = 1'b0;

        // 1: store word 42 at 10, then load it back.
        d_txn("t1_sw", 32'd10, 32'd42, MEM_READ_NONE, MEM_WRITE_W, MEM_READ_NONE, MEM_WRITE_W, 32'd0);
        d_txn("t1_lw", 32'd10, 32'd0, MEM_READ_LW, MEM_WRITE_NONE, MEM_READ_LW, MEM_WRITE_NONE, 32'd42);

        // 2: fetch at 10 and load at 20 in the same cycle; data wins.
        @(posedge clk); #1;
        bus.d_req_valid  = 1'b1;
        bus.d_addr       = 32'd20;
        bus.d_read       = MEM_READ_LW;
        bus.d_write      = MEM_WRITE_NONE;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'd10;
        @(negedge clk);
        check("t2_d_ready", 32'(bus.d_req_ready), 32'd1);
        check("t2_if_ready", 32'(bus.if_req_ready), 32'd0);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        check("t2_d_acc_addr", bus.ram_address, 32'd20);
        check("t2_d_acc_rd", 32'(bus.ram_mem_read), 32'(MEM_READ_LW));
        check("t2_if_ready_acc", 32'(bus.if_req_ready), 32'd0);
        @(negedge clk);
        check("t2_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
        check("t2_d_rsp_data", bus.d_rsp_data, 32'd7);
        check("t2_if_ready_rsp", 32'(bus.if_req_ready), 32'd0);
        @(negedge clk);
        check("t2_if_ready_n3", 32'(bus.if_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        check("t2_if_acc_addr", bus.ram_address, 32'd10);
        check("t2_if_acc_rd", 32'(bus.ram_mem_read), 32'(MEM_READ_LW));
        check("t2_if_acc_wr", 32'(bus.ram_mem_write), 32'd0);
        @(negedge clk);
        check("t2_if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
        check("t2_if_rsp_data", bus.if_rsp_data, 32'd42);
        check("t2_d_rsp_quiet", 32'(bus.d_rsp_valid), 32'd0);
        @(negedge clk);
        check("t2_if_pulse_end", 32'(bus.if_rsp_valid), 32'd0);

        // 3: both ports continuously valid for four grants (1 = data, 0 = fetch).
        @(posedge clk); #1;
        bus.d_req_valid  = 1'b1;
        bus.d_addr       = 32'd20;
        bus.d_read       = MEM_READ_LW;
        bus.d_write      = MEM_WRITE_NONE;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'd0;
        for (int g = 0; g < 4; g++) begin
            who = 2'd2;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.d_req_ready || bus.if_req_ready) begin
                    check("t3_one_ready", 32'(bus.d_req_ready & bus.if_req_ready), 32'd0);
                    who = bus.d_req_ready ? 2'd1 : 2'd0;
                    break;
                end
            end
            check($sformatf("t3_grant%0d", g), 32'(who), 32'(exp_g[g]));
        end
        @(posedge clk); #1;
        bus.d_req_valid  = 1'b0;
        bus.if_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_back_idle", 32'(state), 32'(ST_IDLE));

        // 4: byte store 0xAB at 4, then read it back zero- and sign-extended.
        d_txn("t4_sb", 32'd4, 32'h0000_00AB, MEM_READ_NONE, MEM_WRITE_B, MEM_READ_NONE, MEM_WRITE_B, 32'd0);
        d_txn("t4_lbu", 32'd4, 32'd0, MEM_READ_LBU, MEM_WRITE_NONE, MEM_READ_LBU, MEM_WRITE_NONE, 32'h0000_00AB);
        d_txn("t4_lb", 32'd4, 32'd0, MEM_READ_LB, MEM_WRITE_NONE, MEM_READ_LB, MEM_WRITE_NONE, 32'hFFFF_FFAB);

        // 5: reset during the ACCESS cycle of a load drops its response.
        snap = d_rsp_cnt;
        @(posedge clk); #1;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'd20;
        bus.d_read      = MEM_READ_LW;
        bus.d_write     = MEM_WRITE_NONE;
        wait_d_ready("t5_first");
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_access", 32'(state), 32'(ST_ACCESS));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'd10;
        @(negedge clk);
        check("t5_post_state", 32'(state), 32'(ST_IDLE));
        check("t5_post_rd", 32'(bus.ram_mem_read), 32'd0);
        check("t5_post_wr", 32'(bus.ram_mem_write), 32'd0);
        check("t5_post_rsp", 32'(bus.d_rsp_valid), 32'd0);
        check("t5_post_rsp_data", bus.d_rsp_data, 32'd0);
        check("t5_refire", 32'(bus.d_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        check("t5_acc_addr", bus.ram_address, 32'd10);
        @(negedge clk);
        check("t5_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
        check("t5_rsp_data", bus.d_rsp_data, 32'd42);
        @(negedge clk);
        check("t5_rsp_count", 32'(d_rsp_cnt - snap), 32'd1);

        // 6: load and store codes together -> store only; then a no-op.
        d_txn("t6_both", 32'd16, 32'h1234_5678, MEM_READ_LW, MEM_WRITE_W, MEM_READ_NONE, MEM_WRITE_W, 32'd0);
        d_txn("t6_lw", 32'd16, 32'd0, MEM_READ_LW, MEM_WRITE_NONE, MEM_READ_LW, MEM_WRITE_NONE, 32'h1234_5678);
        d_txn("t6_noop", 32'd16, 32'd0, MEM_READ_NONE, MEM_WRITE_NONE, MEM_READ_NONE, MEM_WRITE_NONE, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single shared `ram` block. It accepts word instruction fetches from the fetch stage and load/store requests from the memory stage. It serializes both streams onto the one RAM port, holds each command stable for the RAM latency, and returns read data or a write acknowledge to the requester that issued it.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: data width.
- `RAM_LATENCY`, default 1, legal range 1..7: cycles from command presentation to valid `ram_data_out`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch accepted this cycle.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_rsp_valid`  out  1  one-cycle pulse; fetch data valid.
- `if_rsp_data`  out  DATA_WIDTH  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_read`  in  3  load code: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `d_write`  in  2  store code: 0 none, 1 byte, 2 half, 3 word.
- `d_rsp_valid`  out  1  one-cycle pulse; load data valid or store acknowledged.
- `d_rsp_data`  out  DATA_WIDTH  load data; 0 for stores.
- `ram_address`  out  ADDR_WIDTH  RAM address.
- `ram_data_in`  out  DATA_WIDTH  RAM write data.
- `ram_mem_read`  out  3  RAM read code.
- `ram_mem_write`  out  2  RAM write code.
- `ram_data_out`  in  DATA_WIDTH  RAM read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Grant is chosen combinationally from the valid signals.
  - Only the granted port's `*_req_ready` is high; ready is low in every other state.
  - A request fires when valid && ready. On fire:
    - latch address, write data, and codes into command registers;
    - record the owner port;
    - load the latency counter with RAM_LATENCY;
    - go to ACCESS.
- **ACCESS**
  - `ram_address`, `ram_data_in` and `ram_mem_read` come from the command registers.
  - `ram_mem_write` is nonzero only in the first ACCESS cycle, so each store writes exactly once.
  - The counter decrements each cycle. When it reaches 0, capture `ram_data_out` into the owner's response register and go to RESP.
- **RESP**
  - Owner's `*_rsp_valid` is high for exactly one cycle, then return to IDLE.
  - No backpressure on responses.
- **Fetch commands**: always `ram_mem_read`=3 (LW), `ram_mem_write`=0.
- **Data commands**: `d_read` and `d_write` are forwarded unchanged.
  - Both nonzero: the write wins and the read code is forced to 0.
  - Both zero: no-op. No RAM strobe; acknowledged with normal latency, `d_rsp_data`=0.
- **Requester rule**: valid and payload stay stable until ready. The arbiter keeps no request queue.

## Timing
- Request fires in cycle N; ACCESS occupies N+1..N+RAM_LATENCY; rsp_valid is high in N+RAM_LATENCY+1.
- Next request can fire in N+RAM_LATENCY+2, giving a throughput of one access per RAM_LATENCY+2 cycles.
- Reset values:
  - state IDLE;
  - all `*_ready` and `*_rsp_valid` 0;
  - `ram_mem_read`=0, `ram_mem_write`=0;
  - `ram_address`, `ram_data_in`, `if_rsp_data`, `d_rsp_data` all 0;
  - round-robin pointer = fetch (data wins the first tie).
- Outside ACCESS, `ram_mem_read` and `ram_mem_write` are 0. `ram_address` and `ram_data_in` hold their last value.
- Response data registers hold until the next response to the same port.
- Reset mid-access: the next cycle is IDLE with strobes 0. The pending response is dropped and no rsp_valid pulse is generated.
- If both ports are valid in the same IDLE cycle, exactly one ready is asserted.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit last-grant pointer alternates priority on ties. It updates only on fire.
  - Undefined: fixed priority, data over fetch. No pointer register exists.

## Structure
- Shared package `mem_pkg` holds:
  - read codes (`MEM_READ_NONE`, `MEM_READ_LB`..`MEM_READ_LHU`);
  - write codes (`MEM_WRITE_NONE`, `MEM_WRITE_B`, `MEM_WRITE_H`, `MEM_WRITE_W`);
  - FSM state encoding;
  - port-id constants `PORT_IF` and `PORT_D`.
- One sub-module, `arb_grant`: purely combinational pick from the two valids and the pointer. Holds all macro-dependent logic.

## Test plan
RAM_LATENCY=1, real `ram` attached.
1. Data store word 42 to address 10, then load LW from 10 → store ack pulse at N+2 with `ram_mem_write`=3 for one cycle; load `d_rsp_data`=42 at M+2.
2. Fetch address 10 and data load address 20 (holds 7) valid in the same cycle, no macro → data fires first and `d_rsp_data`=7 at N+2; fetch fires at N+3 and `if_rsp_data`=42 at N+5.
3. `ARB_ROUND_ROBIN_EN` defined, both ports continuously valid for 4 grants → grant order D, F, D, F.
4. Byte store (`d_write`=1), `d_wdata`=0xAB, address 4 → `ram_mem_write`=1 for exactly one cycle, `ram_data_in`=0xAB, `ram_address`=4.
5. `rst` asserted in the ACCESS cycle of a load → next cycle strobes are 0, no rsp_valid ever appears, and a new request fires the cycle after `rst` deasserts.
6. `d_read`=3 and `d_write`=3 together → `ram_mem_read`=0, store performed, ack pulse with `d_rsp_data`=0.
